// File: rtl/psg_seq_pkg.sv
// Shared types for the PSG bus sequencer: FSM states, request record and
// the default register image written by the init sequence.
package psg_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, R_STB, RECOVER
  } psg_state_e;

  localparam int INIT_NUM_REGS = 16;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } psg_req_t;

  // R7=3F keeps tone/noise muted and the I/O ports as inputs; R14/R15 idle high.
  function automatic logic [7:0] psg_init_value(input logic [3:0] addr);
    case (addr)
      4'd7:         return 8'h3F;
      4'd14, 4'd15: return 8'hFF;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/psg_req_fifo.sv
// Show-ahead synchronous FIFO for queued CPU requests; full is registered so
// the upstream ready is a clean flop output.
module psg_req_fifo
  import psg_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  psg_req_t wdata,
  output psg_req_t rdata,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  psg_req_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            full_q, full_d;
  logic            do_push, do_pop;

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d   = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/psg_bus_sequencer.sv
// Expands queued CPU register accesses and the init image into timed
// cs_n/asel/wr_n/rd_n strobes for an indirectly addressed PSG.
module psg_bus_sequencer
  import psg_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STB_CYCLES = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_start,
  output logic       init_busy,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       psg_cs_n,
  output logic       psg_asel,
  output logic       psg_wr_n,
  output logic       psg_rd_n,
  output logic [7:0] psg_di,
  input  logic [7:0] psg_do
);
  localparam int CNT_MAX = (STB_CYCLES > GAP_CYCLES) ? STB_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  psg_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  psg_req_t   cur_q, cur_d;
  logic       cur_init_q, cur_init_d;
  logic       init_busy_q, init_busy_d;
  logic [3:0] init_ptr_q, init_ptr_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       cs_n_q, cs_n_d, asel_q, asel_d, wr_n_q, wr_n_d, rd_n_q, rd_n_d;
  logic [7:0] di_q, di_d;

  psg_req_t   fifo_head;
  logic       fifo_pop, fifo_full, fifo_empty;
  logic       stb_last, gap_last;

  psg_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .pop   (fifo_pop),
    .wdata ('{we: req_we, addr: req_addr, wdata: req_wdata}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign stb_last = (cnt_q == CW'(STB_CYCLES - 1));
  assign gap_last = (cnt_q == CW'(GAP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      cur_init_q  <= 1'b0;
      init_busy_q <= 1'b0;
      init_ptr_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      cs_n_q      <= 1'b1;
      asel_q      <= 1'b0;
      wr_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      di_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      cur_init_q  <= cur_init_d;
      init_busy_q <= init_busy_d;
      init_ptr_q  <= init_ptr_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      cs_n_q      <= cs_n_d;
      asel_q      <= asel_d;
      wr_n_q      <= wr_n_d;
      rd_n_q      <= rd_n_d;
      di_q        <= di_d;
    end
  end

  // Arbitration only happens in IDLE, so a started CPU access always finishes first.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cur_init_d = cur_init_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (init_busy_q) begin
          state_d    = A_SET;
          cur_init_d = 1'b1;
          cur_d      = '{we: 1'b1, addr: init_ptr_q, wdata: psg_init_value(init_ptr_q)};
        end else if (!fifo_empty) begin
          state_d    = A_SET;
          cur_init_d = 1'b0;
          cur_d      = fifo_head;
          fifo_pop   = 1'b1;
        end
      end
      A_SET:   state_d = A_STB;
      A_STB:   if (stb_last) state_d = A_HLD;
      A_HLD:   state_d = cur_q.we ? D_SET : R_STB;
      D_SET:   state_d = D_STB;
      D_STB:   if (stb_last) state_d = D_HLD;
      D_HLD:   state_d = RECOVER;
      R_STB:   if (stb_last) state_d = RECOVER;
      RECOVER: if (gap_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
  end

  always_comb begin
    init_busy_d = init_busy_q;
    init_ptr_d  = init_ptr_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    if (init_start && !init_busy_q) init_busy_d = 1'b1;
    if (state_q == RECOVER && gap_last && cur_init_q) begin
      init_ptr_d = init_ptr_q + 4'd1;
      if (init_ptr_q == 4'(INIT_NUM_REGS - 1)) init_busy_d = 1'b0;
    end
    if (state_q == R_STB && stb_last) begin
      rd_valid_d = 1'b1;
      rd_data_d  = psg_do;
    end
  end

  // Pins are decoded from the next state so they land in flops aligned with state_q.
  always_comb begin
    cs_n_d = 1'b1;
    asel_d = 1'b0;
    wr_n_d = 1'b1;
    rd_n_d = 1'b1;
    di_d   = '0;
    case (state_d)
      A_SET, A_HLD: begin cs_n_d = 1'b0; asel_d = 1'b1; di_d = {4'h0, cur_d.addr}; end
      A_STB:        begin cs_n_d = 1'b0; asel_d = 1'b1; di_d = {4'h0, cur_d.addr}; wr_n_d = 1'b0; end
      D_SET, D_HLD: begin cs_n_d = 1'b0; di_d = cur_d.wdata; end
      D_STB:        begin cs_n_d = 1'b0; di_d = cur_d.wdata; wr_n_d = 1'b0; end
      R_STB:        begin cs_n_d = 1'b0; rd_n_d = 1'b0; end
      default: ;
    endcase
  end

  assign init_busy = init_busy_q;
  assign req_ready = !fifo_full;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign psg_cs_n  = cs_n_q;
  assign psg_asel  = asel_q;
  assign psg_wr_n  = wr_n_q;
  assign psg_rd_n  = rd_n_q;
  assign psg_di    = di_q;

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Bench for psg_bus_sequencer: a behavioural PSG on the pins, a per-feature
// task sequence and an in-order register model for random traffic.
module tb_psg_bus_sequencer;
  logic       clk = 1'b0, rst = 1'b1, init_start = 1'b0;
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [3:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       init_busy, req_ready, rd_valid;
  logic [7:0] rd_data, psg_di, psg_do;
  logic       psg_cs_n, psg_asel, psg_wr_n, psg_rd_n;

  always #5 clk = ~clk;

  psg_bus_sequencer #(.FIFO_DEPTH(4), .STB_CYCLES(2), .GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .init_busy(init_busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rd_valid(rd_valid),
    .rd_data(rd_data), .psg_cs_n(psg_cs_n), .psg_asel(psg_asel),
    .psg_wr_n(psg_wr_n), .psg_rd_n(psg_rd_n), .psg_di(psg_di), .psg_do(psg_do)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural PSG: both latches capture on the wr_n rising edge while selected.
  logic [7:0]  psg_regs [16] = '{default: 8'hAA};
  logic [3:0]  psg_lat = '0;
  logic        prev_wr_n = 1'b1, prev_cs_n = 1'b1;
  logic [11:0] wr_log [$];
  logic [7:0]  rd_log [$];
  int          rd_cyc [$];
  int          cs_fall [$];

  assign psg_do = psg_rd_n ? 8'h00 : psg_regs[psg_lat];

  always @(negedge clk) begin
    if (!psg_cs_n && !prev_wr_n && psg_wr_n) begin
      if (psg_asel) psg_lat = psg_di[3:0];
      else begin
        psg_regs[psg_lat] = psg_di;
        wr_log.push_back({psg_lat, psg_di});
      end
    end
    if (prev_cs_n && !psg_cs_n) cs_fall.push_back(cyc);
    prev_wr_n = psg_wr_n;
    prev_cs_n = psg_cs_n;
    if (rd_valid) begin rd_log.push_back(rd_data); rd_cyc.push_back(cyc); end
  end

  function automatic logic [7:0] img(input int r);
    if (r == 7) return 8'h3F;
    if (r >= 14) return 8'hFF;
    return 8'h00;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic we, input logic [3:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    for (int k = 0; k < 300; k++) begin
      if (req_ready) begin tick(); req_valid = 1'b0; return; end
      tick();
    end
    req_valid = 1'b0;
    n_cmp++; n_err++;
    $display("FAIL push_timeout: req_ready stayed 0, required 1 within 300 cycles");
  endtask

  task automatic wait_quiet(input int limit);
    int q = 0;
    for (int k = 0; k < limit; k++) begin
      tick();
      if (psg_cs_n && !init_busy) q++; else q = 0;
      if (q >= 16) return;
    end
    n_cmp++; n_err++;
    $display("FAIL wait_quiet: bus still active after %0d cycles", limit);
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick();
    n_cmp++; if ({psg_cs_n, psg_wr_n, psg_rd_n, psg_asel} !== 4'b1110) begin n_err++;
      $display("FAIL reset_strobes: got %b want 1110", {psg_cs_n, psg_wr_n, psg_rd_n, psg_asel}); end
    n_cmp++; if (psg_di !== 8'h00) begin n_err++; $display("FAIL reset_di: got %h want 00", psg_di); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    n_cmp++; if (init_busy !== 1'b0) begin n_err++; $display("FAIL reset_init_busy: got %b want 0", init_busy); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    rst = 1'b0; tick();
  endtask

  task automatic test_cpu_write();
    logic [11:0] tr [40];
    logic [11:0] e;
    int a;
    wr_log.delete();
    push(1'b1, 4'd8, 8'h0F);
    for (int k = 0; k < 40; k++) begin tr[k] = {psg_cs_n, psg_asel, psg_wr_n, psg_rd_n, psg_di}; tick(); end
    a = -1;
    for (int k = 0; k < 40; k++) if (a < 0 && tr[k][11] == 1'b0) a = k;
    n_cmp++;
    if (a < 0 || a > 28) begin n_err++; $display("FAIL wr_start: cs_n low at index %0d, want 0..28", a); end
    else begin
      // Phases: A_SET, A_STB x2, A_HLD, D_SET, D_STB x2, D_HLD, RECOVER x4.
      for (int k = 0; k < 12; k++) begin
        e = {(k < 8) ? 1'b0 : 1'b1, (k < 4) ? 1'b1 : 1'b0,
             (k == 1 || k == 2 || k == 5 || k == 6) ? 1'b0 : 1'b1, 1'b1,
             (k < 4) ? 8'h08 : (k < 8) ? 8'h0F : 8'h00};
        n_cmp++; if (tr[a+k] !== e) begin n_err++;
          $display("FAIL wr_wave[%0d]: got %h want %h", k, tr[a+k], e); end
      end
    end
    n_cmp++; if (psg_regs[8] !== 8'h0F) begin n_err++; $display("FAIL wr_vol_a: got %h want 0F", psg_regs[8]); end
    n_cmp++; if (wr_log.size() != 1) begin n_err++; $display("FAIL wr_count: got %0d want 1", wr_log.size()); end
  endtask

  task automatic test_init();
    int busy_len = 1, k;
    logic done = 1'b0;
    wr_log.delete();
    init_start = 1'b1; tick(); init_start = 1'b0;
    n_cmp++; if (init_busy !== 1'b1) begin n_err++; $display("FAIL init_busy_rise: got %b want 1", init_busy); end
    for (k = 0; k < 400 && !done; k++) begin
      init_start = (k == 40);
      tick();
      if (init_busy) busy_len++; else done = 1'b1;
    end
    init_start = 1'b0;
    n_cmp++; if (!done || busy_len < 192 || busy_len > 210) begin n_err++;
      $display("FAIL init_busy_len: got %0d cycles (done=%b) want 192..210", busy_len, done); end
    n_cmp++; if (wr_log.size() != 16) begin n_err++; $display("FAIL init_count_at_fall: got %0d want 16", wr_log.size()); end
    repeat (30) tick();
    n_cmp++; if (wr_log.size() != 16) begin n_err++; $display("FAIL init_retrigger: got %0d writes want 16", wr_log.size()); end
    for (int r = 0; r < 16 && r < wr_log.size(); r++) begin
      n_cmp++; if (wr_log[r] !== {4'(r), img(r)}) begin n_err++;
        $display("FAIL init_img[%0d]: got %h want %h", r, wr_log[r], {4'(r), img(r)}); end
    end
  endtask

  task automatic test_cpu_read();
    logic [4:0] tr [40];
    logic [7:0] di_t [40], rdd [40];
    logic [4:0] e;
    int a;
    push(1'b0, 4'd7, 8'h00);
    for (int k = 0; k < 40; k++) begin
      tr[k] = {psg_cs_n, psg_asel, psg_wr_n, psg_rd_n, rd_valid}; di_t[k] = psg_di; rdd[k] = rd_data; tick();
    end
    a = -1;
    for (int k = 0; k < 40; k++) if (a < 0 && tr[k][4] == 1'b0) a = k;
    n_cmp++;
    if (a < 0 || a > 30) begin n_err++; $display("FAIL rd_start: cs_n low at index %0d, want 0..30", a); end
    else begin
      // Phases: A_SET, A_STB x2, A_HLD, R_STB x2, RECOVER x4; rd_valid in first RECOVER.
      for (int k = 0; k < 10; k++) begin
        e = {(k < 6) ? 1'b0 : 1'b1, (k < 4) ? 1'b1 : 1'b0, (k == 1 || k == 2) ? 1'b0 : 1'b1,
             (k == 4 || k == 5) ? 1'b0 : 1'b1, (k == 6) ? 1'b1 : 1'b0};
        n_cmp++; if (tr[a+k] !== e) begin n_err++; $display("FAIL rd_wave[%0d]: got %b want %b", k, tr[a+k], e); end
      end
      n_cmp++; if (di_t[a] !== 8'h07) begin n_err++; $display("FAIL rd_addr: got %h want 07", di_t[a]); end
      n_cmp++; if (rdd[a+6] !== 8'h3F) begin n_err++; $display("FAIL rd_data: got %h want 3F", rdd[a+6]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q [$];
    logic [3:0] ad [5];
    logic [7:0] dd [5];
    int acc = 0;
    logic seen4 = 1'b0, rdy_at4 = 1'b1, rdy;
    wr_log.delete(); cs_fall.delete();
    exp_q.push_back(12'h1A5);
    push(1'b1, 4'h1, 8'hA5);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin ad[i] = 4'($urandom); dd[i] = 8'($urandom); exp_q.push_back({ad[i], dd[i]}); end
    for (int k = 0; k < 300 && acc < 5; k++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = ad[acc]; req_wdata = dd[acc];
      rdy = req_ready; tick();
      if (rdy) acc++;
      if (acc == 4 && !seen4) begin seen4 = 1'b1; rdy_at4 = req_ready; end
    end
    req_valid = 1'b0;
    n_cmp++; if (rdy_at4 !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop: got %b want 0", rdy_at4); end
    wait_quiet(200);
    n_cmp++; if (wr_log.size() != 6) begin n_err++; $display("FAIL b2b_count: got %0d want 6", wr_log.size()); end
    for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
      n_cmp++; if (wr_log[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_order[%0d]: got %h want %h", i, wr_log[i], exp_q[i]); end
    end
    // Each queued write: 12 cycles of transaction plus one IDLE arbitration cycle.
    for (int i = 1; i < 6 && i < cs_fall.size(); i++) begin
      n_cmp++; if (cs_fall[i] - cs_fall[i-1] != 13) begin n_err++;
        $display("FAIL b2b_spacing[%0d]: got %0d want 13", i, cs_fall[i] - cs_fall[i-1]); end
    end
  endtask

  task automatic test_init_interleave();
    int fall_cyc = -1;
    logic [3:0] ra1, ra2;
    wr_log.delete(); rd_log.delete(); rd_cyc.delete();
    ra1 = 4'($urandom); ra2 = 4'($urandom);
    push(1'b1, 4'd3, 8'h5A);
    for (int k = 0; k < 50 && psg_cs_n; k++) tick();
    init_start = 1'b1; tick(); init_start = 1'b0;
    push(1'b0, ra1, 8'h00);
    push(1'b0, ra2, 8'h00);
    for (int k = 0; k < 600 && fall_cyc < 0; k++) begin tick(); if (!init_busy) fall_cyc = cyc; end
    wait_quiet(200);
    n_cmp++; if (wr_log.size() != 17) begin n_err++; $display("FAIL ilv_count: got %0d want 17", wr_log.size()); end
    n_cmp++; if (wr_log.size() > 0 && wr_log[0] !== 12'h35A) begin n_err++;
      $display("FAIL ilv_cpu_first: got %h want 35A", wr_log[0]); end
    for (int r = 0; r < 16 && r + 1 < wr_log.size(); r++) begin
      n_cmp++; if (wr_log[r+1] !== {4'(r), img(r)}) begin n_err++;
        $display("FAIL ilv_img[%0d]: got %h want %h", r, wr_log[r+1], {4'(r), img(r)}); end
    end
    n_cmp++; if (rd_log.size() != 2) begin n_err++; $display("FAIL ilv_rd_count: got %0d want 2", rd_log.size()); end
    else begin
      n_cmp++; if (rd_log[0] !== img(int'(ra1)) || rd_log[1] !== img(int'(ra2))) begin n_err++;
        $display("FAIL ilv_rd_data: got %h %h want %h %h", rd_log[0], rd_log[1], img(int'(ra1)), img(int'(ra2))); end
      n_cmp++; if (fall_cyc < 0 || rd_cyc[0] < fall_cyc) begin n_err++;
        $display("FAIL ilv_rd_after_init: got rd at %0d want after %0d", rd_cyc[0], fall_cyc); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  ref_regs [16];
    logic [11:0] exp_w [$];
    logic [7:0]  exp_r [$];
    logic we; logic [3:0] a; logic [7:0] d;
    wr_log.delete(); rd_log.delete();
    for (int i = 0; i < 16; i++) ref_regs[i] = psg_regs[i];
    for (int i = 0; i < 30; i++) begin
      we = 1'($urandom); a = 4'($urandom); d = 8'($urandom);
      if (we) begin ref_regs[a] = d; exp_w.push_back({a, d}); end
      else exp_r.push_back(ref_regs[a]);
      push(we, a, d);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_quiet(1000);
    n_cmp++; if (wr_log.size() != exp_w.size() || rd_log.size() != exp_r.size()) begin n_err++;
      $display("FAIL rnd_counts: got %0d/%0d want %0d/%0d", wr_log.size(), rd_log.size(), exp_w.size(), exp_r.size()); end
    for (int i = 0; i < exp_w.size() && i < wr_log.size(); i++) begin
      n_cmp++; if (wr_log[i] !== exp_w[i]) begin n_err++; $display("FAIL rnd_wr[%0d]: got %h want %h", i, wr_log[i], exp_w[i]); end
    end
    for (int i = 0; i < exp_r.size() && i < rd_log.size(); i++) begin
      n_cmp++; if (rd_log[i] !== exp_r[i]) begin n_err++; $display("FAIL rnd_rd[%0d]: got %h want %h", i, rd_log[i], exp_r[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int wr_at_rst, n_cs = 0, n_rv = 0;
    logic found = 1'b0;
    wr_log.delete(); rd_log.delete();
    for (int i = 0; i < 5; i++) push(1'b1, 4'(i + 9), 8'(8'h70 + i));
    for (int k = 0; k < 80 && !found; k++) begin
      if (!psg_cs_n && !psg_asel && !psg_wr_n) found = 1'b1; else tick();
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL rstm_find: D_STB not seen, want seen"); end
    wr_at_rst = wr_log.size();
    rst = 1'b1; tick();
    n_cmp++; if ({psg_wr_n, psg_cs_n} !== 2'b11) begin n_err++;
      $display("FAIL rstm_strobes: got wr_n,cs_n=%b want 11", {psg_wr_n, psg_cs_n}); end
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstm_ready: got %b want 1", req_ready); end
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin tick(); if (!psg_cs_n) n_cs++; if (rd_valid) n_rv++; end
    n_cmp++; if (n_cs != 0 || n_rv != 0) begin n_err++;
      $display("FAIL rstm_quiet: got %0d cs cycles, %0d rd_valid want 0,0", n_cs, n_rv); end
    n_cmp++; if (wr_log.size() != wr_at_rst) begin n_err++;
      $display("FAIL rstm_no_write: got %0d writes want %0d", wr_log.size(), wr_at_rst); end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_init();
    test_cpu_read();
    test_back_to_back();
    test_init_interleave();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
